// File: rtl/fetch_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_buffer_pkg
// Brief    : Shared types and constants for the fetch buffer.
// Revision : 1.0
// ============================================================================
package fetch_buffer_pkg;

    localparam int FETCH_BUFFER_STALL_MARGIN = 4;

    typedef struct packed {
        logic [15:0] hw;
        logic [30:0] pc;
        logic        fault;
    } fetch_buffer_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_buffer_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_buffer_queue
// Brief    : Circular queue with 0/1/2 entry push and pop per cycle.
// Revision : 1.0
// ============================================================================
module fetch_buffer_queue
    import fetch_buffer_pkg::*;
#(
    parameter int  DEPTH = 8,
    parameter type T     = fetch_buffer_entry_t
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_flush,
    input  logic [1:0]               i_push_n,
    input  T                         i_push_e0,
    input  T                         i_push_e1,
    input  logic [1:0]               i_pop_n,
    output T                         o_head0,
    output T                         o_head1,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    T                r_mem [DEPTH];
    logic [PW-1:0]   r_head;
    logic [PW-1:0]   r_tail;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   w_free;
    logic [1:0]      w_push_n;

    // A push that does not fit is dropped whole rather than partially applied.
    assign w_free   = CW'(DEPTH) - r_count;
    assign w_push_n = (CW'(i_push_n) <= w_free) ? i_push_n : 2'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PW'(i_pop_n);
            r_tail  <= r_tail + PW'(w_push_n);
            r_count <= r_count + CW'(w_push_n) - CW'(i_pop_n);
        end
    end

    always_ff @(posedge clk) begin
        if (!i_flush) begin
            if (w_push_n != 2'd0) begin
                r_mem[r_tail] <= i_push_e0;
            end
            if (w_push_n == 2'd2) begin
                r_mem[r_tail + PW'(1)] <= i_push_e1;
            end
        end
    end

    assign o_head0 = r_mem[r_head];
    assign o_head1 = r_mem[r_head + PW'(1)];
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_buffer
// Brief    : Halfword fetch queue reassembling RV32/RVC instructions for decode.
// Revision : 1.0
// ============================================================================
module fetch_buffer
    import fetch_buffer_pkg::*;
#(
    parameter int LINE_WIDTH = 128,
    parameter int DEPTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic                  in_fault,
    input  logic [31:0]           in_pc,
    input  logic [LINE_WIDTH-1:0] in_line,
    output logic                  stall_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_pc,
    output logic [31:0]           out_insn,
    output logic                  out_compressed,
    output logic                  out_fault
);

    localparam int OW = $clog2(LINE_WIDTH / 8);
    localparam int IW = OW - 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [IW-1:0]       w_idx0;
    logic [IW-1:0]       w_idx1;
    logic [15:0]         w_hw0;
    logic [15:0]         w_hw1;
    logic [1:0]          w_push_n;
    fetch_buffer_entry_t w_push_e0;
    fetch_buffer_entry_t w_push_e1;
    logic [1:0]          w_pop_n;
    fetch_buffer_entry_t w_head0;
    fetch_buffer_entry_t w_head1;
    logic [CW-1:0]       w_count;
    logic                w_rvc;
    logic                w_single;
    logic                w_unused;

    assign w_unused = &{1'b0, in_pc[0]};

    // Aligned 32-bit fetches have an even index, so idx+1 never leaves the line.
    assign w_idx0 = in_pc[OW-1:1];
    assign w_idx1 = w_idx0 | IW'(1);
    assign w_hw0  = in_line[{w_idx0, 4'b0000} +: 16];
    assign w_hw1  = in_line[{w_idx1, 4'b0000} +: 16];

    always_comb begin
        w_push_n  = 2'd0;
        w_push_e0 = '0;
        w_push_e1 = '0;
        if (in_valid && !flush) begin
            if (in_fault) begin
                w_push_n  = 2'd1;
                w_push_e0 = '{hw: 16'h0, pc: in_pc[31:1], fault: 1'b1};
            end else if (in_pc[1]) begin
                w_push_n  = 2'd1;
                w_push_e0 = '{hw: w_hw0, pc: in_pc[31:1], fault: 1'b0};
            end else begin
                w_push_n  = 2'd2;
                w_push_e0 = '{hw: w_hw0, pc: in_pc[31:1], fault: 1'b0};
                w_push_e1 = '{hw: w_hw1, pc: in_pc[31:1] + 31'd1, fault: 1'b0};
            end
        end
    end

    fetch_buffer_queue #(
        .DEPTH (DEPTH),
        .T     (fetch_buffer_entry_t)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .i_flush   (flush),
        .i_push_n  (w_push_n),
        .i_push_e0 (w_push_e0),
        .i_push_e1 (w_push_e1),
        .i_pop_n   (w_pop_n),
        .o_head0   (w_head0),
        .o_head1   (w_head1),
        .o_count   (w_count)
    );

    // A fault entry stands alone even if its halfword would decode as 32-bit.
    assign w_rvc     = (w_head0.hw[1:0] != 2'b11);
    assign w_single  = w_rvc || w_head0.fault;
    assign out_valid = (w_count != '0) && (w_single || (w_count >= CW'(2)));
    assign w_pop_n   = (out_valid && out_ready && !flush) ? (w_single ? 2'd1 : 2'd2) : 2'd0;

    always_comb begin
        out_pc         = 32'h0;
        out_insn       = 32'h0;
        out_compressed = 1'b0;
        out_fault      = 1'b0;
        if (out_valid) begin
            out_pc = {w_head0.pc, 1'b0};
            if (w_single) begin
                out_insn       = {16'h0, w_head0.hw};
                out_compressed = w_rvc && !w_head0.fault;
                out_fault      = w_head0.fault;
            end else begin
                out_insn  = {w_head1.hw, w_head0.hw};
                out_fault = w_head1.fault;
            end
        end
    end

    // Margin covers one fetch in flight plus one in the current cycle.
    assign stall_out = (CW'(DEPTH) - w_count) < CW'(FETCH_BUFFER_STALL_MARGIN);

endmodule
`default_nettype wire

// File: tb/tb_fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_buffer
// Brief    : Vector table, directed corner sequences and random model checks.
// Revision : 1.0
// ============================================================================
module tb_fetch_buffer;

    localparam int LW    = 128;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_fault;
    logic [31:0]   in_pc;
    logic [LW-1:0] in_line;
    logic          stall_out;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_pc;
    logic [31:0]   out_insn;
    logic          out_compressed;
    logic          out_fault;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_buffer #(
        .LINE_WIDTH (LW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_fault       (in_fault),
        .in_pc          (in_pc),
        .in_line        (in_line),
        .stall_out      (stall_out),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_insn       (out_insn),
        .out_compressed (out_compressed),
        .out_fault      (out_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          fl;
        logic          iv;
        logic          ifa;
        logic [31:0]   pc;
        logic [LW-1:0] line;
        logic          rdy;
        logic          ev;
        logic [31:0]   ei;
        logic [31:0]   ep;
        logic          ec;
        logic          ef;
        logic          es;
    } vec_t;

    typedef struct {
        logic [15:0] hw;
        logic [31:0] pc;
        logic        fault;
    } ent_t;

    vec_t vt[9];
    ent_t mq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic v, input logic [31:0] insn,
                             input logic [31:0] pc, input logic c, input logic f, input logic s);
        chk({tag, ".valid"}, {31'h0, out_valid}, {31'h0, v});
        chk({tag, ".insn"}, out_insn, insn);
        chk({tag, ".pc"}, out_pc, pc);
        chk({tag, ".compressed"}, {31'h0, out_compressed}, {31'h0, c});
        chk({tag, ".fault"}, {31'h0, out_fault}, {31'h0, f});
        chk({tag, ".stall"}, {31'h0, stall_out}, {31'h0, s});
    endtask

    task automatic drive(input logic fl, input logic iv, input logic ifa,
                         input logic [31:0] pc, input logic [LW-1:0] line, input logic rdy);
        flush     = fl;
        in_valid  = iv;
        in_fault  = ifa;
        in_pc     = pc;
        in_line   = line;
        out_ready = rdy;
    endtask

    function automatic vec_t mkv(input logic fl, input logic iv, input logic ifa,
                                 input logic [31:0] pc, input logic [LW-1:0] line,
                                 input logic rdy, input logic ev, input logic [31:0] ei,
                                 input logic [31:0] ep, input logic ec, input logic ef,
                                 input logic es);
        vec_t v;
        v.fl = fl; v.iv = iv; v.ifa = ifa; v.pc = pc; v.line = line; v.rdy = rdy;
        v.ev = ev; v.ei = ei; v.ep = ep; v.ec = ec; v.ef = ef; v.es = es;
        return v;
    endfunction

    // Reference view of the head: what decode should see given the queued halfwords.
    function automatic void model_out(output logic v, output logic [31:0] insn,
                                      output logic [31:0] pc, output logic c,
                                      output logic f, output int pops);
        v = 1'b0; insn = 32'h0; pc = 32'h0; c = 1'b0; f = 1'b0; pops = 0;
        if (mq.size() > 0) begin
            if (mq[0].hw[1:0] != 2'b11 || mq[0].fault) begin
                v    = 1'b1;
                insn = {16'h0, mq[0].hw};
                pc   = mq[0].pc;
                c    = !mq[0].fault;
                f    = mq[0].fault;
                pops = 1;
            end else if (mq.size() > 1) begin
                v    = 1'b1;
                insn = {mq[1].hw, mq[0].hw};
                pc   = mq[0].pc;
                f    = mq[1].fault;
                pops = 2;
            end
        end
    endfunction

    function automatic logic [15:0] pick_hw(input logic [LW-1:0] line, input logic [31:0] pc);
        int slot;
        slot = int'(pc % (LW / 8)) / 2;
        return 16'(line >> (16 * slot));
    endfunction

    function automatic int needed(input logic ifa, input logic [31:0] pc);
        return (ifa || pc[1]) ? 1 : 2;
    endfunction

    task automatic model_clock();
        logic        v, c, f;
        logic [31:0] insn, pc;
        int          pops, free_before;
        ent_t        e;
        free_before = DEPTH - mq.size();
        model_out(v, insn, pc, c, f, pops);
        if (flush) begin
            mq.delete();
        end else begin
            if (v && out_ready) begin
                for (int k = 0; k < pops; k++) void'(mq.pop_front());
            end
            if (in_valid) begin
                if (needed(in_fault, in_pc) > free_before) begin
                    n_fail++;
                    $display("FAIL overflow: push of %0d with %0d free", needed(in_fault, in_pc), free_before);
                end else if (in_fault) begin
                    e.hw = 16'h0; e.pc = in_pc & ~32'h1; e.fault = 1'b1;
                    mq.push_back(e);
                end else begin
                    e.hw = pick_hw(in_line, in_pc); e.pc = in_pc & ~32'h1; e.fault = 1'b0;
                    mq.push_back(e);
                    if (!in_pc[1]) begin
                        e.hw = pick_hw(in_line, in_pc + 32'd2); e.pc = (in_pc & ~32'h1) + 32'd2;
                        mq.push_back(e);
                    end
                end
            end
        end
    endtask

    initial begin
        logic          mv, mc, mf, es;
        logic [31:0]   mi, mp, rpc;
        logic [LW-1:0] rline;
        int            pops;
        logic          rfl, riv, rfa, rrdy;
        int            rdy_pct;

        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, '0, 1'b0);
        repeat (2) @(negedge clk);
        check_out("reset", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        vt[0] = mkv(1'b0, 1'b1, 1'b0, 32'h100, 128'h00A00093, 1'b1,
                    1'b1, 32'h00A00093, 32'h100, 1'b0, 1'b0, 1'b0);
        vt[1] = mkv(1'b0, 1'b1, 1'b0, 32'h104, 128'h45014581_00000000, 1'b1,
                    1'b1, 32'h00004581, 32'h104, 1'b1, 1'b0, 1'b0);
        vt[2] = mkv(1'b0, 1'b0, 1'b0, 32'h0, '0, 1'b1,
                    1'b1, 32'h00004501, 32'h106, 1'b1, 1'b0, 1'b0);
        vt[3] = mkv(1'b0, 1'b0, 1'b0, 32'h0, '0, 1'b1,
                    1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        vt[4] = mkv(1'b0, 1'b1, 1'b0, 32'h10E, {16'h0093, 112'h0}, 1'b1,
                    1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        vt[5] = mkv(1'b0, 1'b1, 1'b0, 32'h110, 128'h450100A0, 1'b0,
                    1'b1, 32'h00A00093, 32'h10E, 1'b0, 1'b0, 1'b0);
        vt[6] = mkv(1'b1, 1'b1, 1'b0, 32'h300, 128'h00A00093, 1'b1,
                    1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        vt[7] = mkv(1'b0, 1'b1, 1'b1, 32'h2000, 128'h00A00093, 1'b0,
                    1'b1, 32'h0, 32'h2000, 1'b0, 1'b1, 1'b0);
        vt[8] = mkv(1'b0, 1'b0, 1'b0, 32'h0, '0, 1'b1,
                    1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

        foreach (vt[i]) begin
            drive(vt[i].fl, vt[i].iv, vt[i].ifa, vt[i].pc, vt[i].line, vt[i].rdy);
            @(negedge clk);
            check_out($sformatf("vec%0d", i), vt[i].ev, vt[i].ei, vt[i].ep, vt[i].ec, vt[i].ef, vt[i].es);
        end

        // Asynchronous reset with three entries queued.
        drive(1'b0, 1'b1, 1'b0, 32'h100, 128'h45014581, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 32'h106, 128'h0001_0000_0000_0000, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 32'h0, '0, 1'b0);
        check_out("prerst", 1'b1, 32'h4581, 32'h100, 1'b1, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1 check_out("asyncrst", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_out("postrst", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 32'h200, 128'h00A00093, 1'b1);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 32'h0, '0, 1'b1);
        check_out("afterrst", 1'b1, 32'h00A00093, 32'h200, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check_out("afterrst_empty", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

        // Backpressure: fill at two entries per cycle, then drain.
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b1, 1'b0, 32'h300, {4{32'h00000013}}, 1'b0);
            @(negedge clk);
            check_out($sformatf("fill%0d", k), 1'b1, 32'h13, 32'h300, 1'b0, 1'b0, (k >= 2));
        end
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b0, 1'b0, 32'h0, '0, 1'b1);
            @(negedge clk);
            if (k < 3)
                check_out($sformatf("drain%0d", k), 1'b1, 32'h13, 32'h300, 1'b0, 1'b0, (k == 0));
            else
                check_out("drained", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        end

        // Random traffic against the queue-of-halfwords reference.
        mq.delete();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            model_out(mv, mi, mp, mc, mf, pops);
            es = (DEPTH - mq.size()) < 4;
            n_tests++;
            if ({out_valid, out_insn, out_pc, out_compressed, out_fault, stall_out} !==
                {mv, mi, mp, mc, mf, es}) begin
                n_fail++;
                $display("FAIL rand%0d: got v=%b i=%h pc=%h c=%b f=%b s=%b expected v=%b i=%h pc=%h c=%b f=%b s=%b",
                         cyc, out_valid, out_insn, out_pc, out_compressed, out_fault, stall_out,
                         mv, mi, mp, mc, mf, es);
            end
            rdy_pct = ((cyc / 500) % 2 == 0) ? 35 : 85;
            rfl   = ($urandom % 32) == 0;
            riv   = ($urandom % 4) != 0;
            rfa   = ($urandom % 10) == 0;
            rpc   = $urandom & 32'hFFFF_FFFE;
            rline = {$urandom, $urandom, $urandom, $urandom};
            rrdy  = ($urandom % 100) < rdy_pct;
            if (needed(rfa, rpc) > DEPTH - mq.size()) riv = 1'b0;
            drive(rfl, riv, rfa, rpc, rline, rrdy);
            @(posedge clk);
            model_clock();
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
